tile_rom_arbiter: RTL and testbench



---
 rtl/tile_rom_arbiter.sv | 143 ++++++++++++++
 tb/tb_tile_rom_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/tile_rom_arbiter.sv
// ============================================================================
// tile_rom_arbiter : round-robin arbiter sharing the 1-cycle tile shape ROM.
// Optional response register stage: TILE_ROM_ARB_RSP_REG_EN.   Rev 1.0
// ============================================================================
`default_nettype none

package tile_rom_pkg;

  typedef enum logic [2:0] {
    TILE_I    = 3'd0,
    TILE_O    = 3'd1,
    TILE_T    = 3'd2,
    TILE_S    = 3'd3,
    TILE_Z    = 3'd4,
    TILE_J    = 3'd5,
    TILE_L    = 3'd6,
    TILE_NONE = 3'd7
  } tile_type_e;

  typedef struct packed {
    logic [15:0] cells;
    logic [1:0]  width_m1;
    logic [1:0]  height_m1;
    logic [1:0]  pivot;
  } shape_info_t;

endpackage

module tile_rom_arbiter
  import tile_rom_pkg::*;
#(
  parameter int num_req_p = 3,
  parameter int rom_lat_p = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [num_req_p-1:0]      req_v_i,
  input  logic [num_req_p-1:0][4:0] req_addr_i,
  output logic [num_req_p-1:0]      req_ready_o,
  output logic [num_req_p-1:0]      rsp_v_o,
  output shape_info_t               rsp_data_o,
  output logic [4:0]                rom_addr_o,
  output logic                      rom_re_o,
  input  shape_info_t               rom_data_i,
  output logic                      busy_o
);

  localparam int PTR_W = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(num_req_p - 1);

  if (rom_lat_p != 1) begin : g_bad_lat
    $fatal(1, "tile_rom_arbiter: rom_lat_p must be 1");
  end

  if (num_req_p < 1 || num_req_p > 8) begin : g_bad_req
    $fatal(1, "tile_rom_arbiter: num_req_p must be in [1,8]");
  end

  logic [PTR_W-1:0]     ptr_r;
  logic [num_req_p-1:0] tag_r;
  logic [num_req_p-1:0] grant;
  logic [PTR_W-1:0]     grant_idx;
  logic [4:0]           addr_mux;

  // Walk the offsets from farthest to nearest so the index closest to ptr_r
  // is the one left standing; reset masks every grant.
  always_comb begin
    int j;
    logic [PTR_W-1:0] sel;
    grant     = '0;
    grant_idx = '0;
    j         = 0;
    sel       = '0;
    if (!reset_i) begin
      for (int i = num_req_p - 1; i >= 0; i--) begin
        j = int'(ptr_r) + i;
        if (j >= num_req_p) begin
          j = j - num_req_p;
        end
        sel = j[PTR_W-1:0];
        if (req_v_i[sel]) begin
          grant      = '0;
          grant[sel] = 1'b1;
          grant_idx  = sel;
        end
      end
    end
  end

  always_comb begin
    addr_mux = '0;
    for (int k = 0; k < num_req_p; k++) begin
      if (grant[k]) begin
        addr_mux = req_addr_i[k];
      end
    end
  end

  assign req_ready_o = grant;
  assign rom_re_o    = |grant;
  assign rom_addr_o  = addr_mux;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_r <= '0;
      tag_r <= '0;
    end else begin
      tag_r <= grant;
      if (|grant) begin
        ptr_r <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      end
    end
  end

`ifdef TILE_ROM_ARB_RSP_REG_EN
  logic [num_req_p-1:0] tag2_r;
  shape_info_t          data_r;

  // Data is only captured on a returning read, so it holds between responses.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tag2_r <= '0;
      data_r <= '0;
    end else begin
      tag2_r <= tag_r;
      if (|tag_r) begin
        data_r <= rom_data_i;
      end
    end
  end

  assign rsp_v_o    = tag2_r;
  assign rsp_data_o = data_r;
  assign busy_o     = (|tag_r) | (|tag2_r);
`else
  assign rsp_v_o    = tag_r;
  assign rsp_data_o = rom_data_i;
  assign busy_o     = |tag_r;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tile_rom_arbiter.sv
// ============================================================================
// tb_tile_rom_arbiter : directed self-checking bench for tile_rom_arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tile_rom_arbiter;
  import tile_rom_pkg::*;

  localparam int DW = $bits(shape_info_t);
`ifdef TILE_ROM_ARB_RSP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                clk = 1'b0;
  logic                reset_i = 1'b1;
  logic [2:0]          req_v = '0;
  logic [2:0][4:0]     req_addr = '0;
  logic [2:0]          req_ready;
  logic [2:0]          rsp_v;
  logic [DW-1:0]       rsp_data;
  logic [4:0]          rom_addr;
  logic                rom_re;
  logic [DW-1:0]       rom_data = '0;
  logic                busy;

  int passed = 0;
  int total  = 0;

  logic [2:0] hist_g [0:2];
  logic [4:0] hist_a [0:2];

  tile_rom_arbiter #(.num_req_p(3), .rom_lat_p(1)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .req_v_i     (req_v),
    .req_addr_i  (req_addr),
    .req_ready_o (req_ready),
    .rsp_v_o     (rsp_v),
    .rsp_data_o  (rsp_data),
    .rom_addr_o  (rom_addr),
    .rom_re_o    (rom_re),
    .rom_data_i  (rom_data),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_f(input logic [4:0] a);
    logic [4:0] m3;
    logic [6:0] p;
    m3 = 5'(a * 5'd3);
    p  = 7'({2'b00, a} + 7'd17);
    return DW'({a, m3, ~a, p});
  endfunction

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) begin
    if (rom_re) rom_data <= rom_f(rom_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 3; i++) begin
      hist_g[i] = '0;
      hist_a[i] = '0;
    end
  endtask

  // One clock cycle: drive requests, check the grant side against the
  // expected grant/address and the response side against the history.
  task automatic cycle(input string tag, input logic [2:0] v,
                       input logic [2:0] eg, input logic [4:0] ea);
    logic exp_busy;
    @(negedge clk);
    req_v = v;
    hist_g[2] = hist_g[1]; hist_a[2] = hist_a[1];
    hist_g[1] = hist_g[0]; hist_a[1] = hist_a[0];
    hist_g[0] = eg;        hist_a[0] = ea;
    #1;
    check({tag, ".ready"}, 32'(req_ready), 32'(eg));
    check({tag, ".rom_re"}, 32'(rom_re), 32'(|eg));
    check({tag, ".rom_addr"}, 32'(rom_addr), 32'(ea));
    check({tag, ".rsp_v"}, 32'(rsp_v), 32'(hist_g[LAT]));
    if (hist_g[LAT] != 3'b000)
      check({tag, ".rsp_data"}, 32'(rsp_data), 32'(rom_f(hist_a[LAT])));
    exp_busy = (hist_g[1] != 3'b000);
    if (LAT == 2) exp_busy = exp_busy | (hist_g[2] != 3'b000);
    check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    req_v   = 3'b111;
    #1;
    check("rst.ready", 32'(req_ready), 32'd0);
    check("rst.rom_re", 32'(rom_re), 32'd0);
    check("rst.rsp_v", 32'(rsp_v), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
`ifdef TILE_ROM_ARB_RSP_REG_EN
    check("rst.rsp_data", 32'(rsp_data), 32'd0);
`endif
    req_v = 3'b000;
    @(negedge clk);
    reset_i = 1'b0;
    clear_hist();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_hist();
    do_reset();

    // Single request from index 0, address 6.
    req_addr[0] = 5'd6;
    cycle("single", 3'b001, 3'b001, 5'd6);
    cycle("single_n1", 3'b000, 3'b000, 5'd0);
    cycle("single_n2", 3'b000, 3'b000, 5'd0);
    cycle("single_n3", 3'b000, 3'b000, 5'd0);

`ifdef TILE_ROM_ARB_RSP_REG_EN
    do_reset();
    req_addr[0] = 5'd9;
    cycle("hold", 3'b001, 3'b001, 5'd9);
    repeat (5) cycle("hold_idle", 3'b000, 3'b000, 5'd0);
    check("hold.rsp_data", 32'(rsp_data), 32'(rom_f(5'd9)));
`endif

    // All three requesters held from reset.
    do_reset();
    req_addr[0] = 5'd1;
    req_addr[1] = 5'd2;
    req_addr[2] = 5'd3;
    cycle("rr0", 3'b111, 3'b001, 5'd1);
    cycle("rr1", 3'b111, 3'b010, 5'd2);
    cycle("rr2", 3'b111, 3'b100, 5'd3);
    cycle("rr3", 3'b111, 3'b001, 5'd1);
    cycle("rr_d1", 3'b000, 3'b000, 5'd0);
    cycle("rr_d2", 3'b000, 3'b000, 5'd0);

    // Wrap fairness: ptr is 1 here; grant to 1 moves it to 2.
    cycle("fair0", 3'b010, 3'b010, 5'd2);
    cycle("fair1", 3'b011, 3'b001, 5'd1);
    cycle("fair2", 3'b011, 3'b010, 5'd2);

    // Reset asserted while the grant to index 2 is in flight.
    cycle("mid", 3'b100, 3'b100, 5'd3);
    #2;
    reset_i = 1'b1;
    #1;
    check("mid_rst.ready", 32'(req_ready), 32'd0);
    check("mid_rst.rom_re", 32'(rom_re), 32'd0);
    req_v = 3'b000;
    @(negedge clk);
    #1;
    check("mid_n1.rsp_v", 32'(rsp_v), 32'd0);
    check("mid_n1.busy", 32'(busy), 32'd0);
    reset_i = 1'b0;
    clear_hist();
    cycle("mid_post", 3'b110, 3'b010, 5'd2);
    cycle("mid_d1", 3'b000, 3'b000, 5'd0);
    cycle("mid_d2", 3'b000, 3'b000, 5'd0);

    // Idle stretch; ptr stays at 2 so a full request grants index 2.
    repeat (10) cycle("idle", 3'b000, 3'b000, 5'd0);
    cycle("ptr_hold", 3'b111, 3'b100, 5'd3);
    cycle("end_d1", 3'b000, 3'b000, 5'd0);
    cycle("end_d2", 3'b000, 3'b000, 5'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
